// File: rtl/dmem_fill_pkg.sv
// Shared configuration and FSM encoding for the data-cache line-fill responder.
package dmem_fill_pkg;

  localparam int DMEM_LINE    = 512;
  localparam int DMEM_BLK_LEN = 58;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } fill_state_e;

endpackage

// File: rtl/dmem_fill_if.sv
// Cache-side fill/invalidate bus between dmem (master) and dmem_fill (slave).
interface dmem_fill_if
  import dmem_fill_pkg::*;
#(
  parameter int LINE_W  = DMEM_LINE,
  parameter int BLK_LEN = DMEM_BLK_LEN
);

  logic [BLK_LEN-1:0] b_addr_d;
  logic               b_rd_d;
  logic [LINE_W-1:0]  b_rdata_d;
  logic               b_dv_d;
  logic [BLK_LEN-1:0] b_inv_addr_d;
  logic               inv;

  modport master (
    output b_addr_d, b_rd_d,
    input  b_rdata_d, b_dv_d, b_inv_addr_d, inv
  );

  modport slave (
    input  b_addr_d, b_rd_d,
    output b_rdata_d, b_dv_d, b_inv_addr_d, inv
  );

endinterface

// File: rtl/dmem_fill_inv_gen.sv
// Invalidate path: registers each external write as a one-cycle inv pulse
// carrying the block address of that write.
module dmem_inv_gen
  import dmem_fill_pkg::*;
#(
  parameter int BLK_LEN = DMEM_BLK_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_wr,
  input  logic [63:0]        ext_wr_addr,
  output logic               inv,
  output logic [BLK_LEN-1:0] inv_addr
);

  localparam int OFF_W = 64 - BLK_LEN;

  logic               inv_d, inv_q;
  logic [BLK_LEN-1:0] addr_d, addr_q;
  logic [OFF_W-1:0]   unused_off;

  assign unused_off = ext_wr_addr[OFF_W-1:0];

  always_comb begin
    inv_d  = ext_wr;
    addr_d = addr_q;
    if (ext_wr) addr_d = ext_wr_addr[63:OFF_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      inv_q  <= inv_d;
      addr_q <= addr_d;
    end
  end

  assign inv      = inv_q;
  assign inv_addr = addr_q;

endmodule

// File: rtl/dmem_fill.sv
// Line-fill responder: reads a cache block beat by beat from a 64-bit memory
// port, restarts the fill if the block is written externally, returns the line.
module dmem_fill
  import dmem_fill_pkg::*;
#(
  parameter int LINE_W  = DMEM_LINE,
  parameter int BLK_LEN = DMEM_BLK_LEN
) (
  input  logic        clk,
  input  logic        rst,
  dmem_fill_if.slave  bus,
  output logic [63:0] m_addr,
  output logic        m_rd,
  input  logic [63:0] m_rdata,
  input  logic        m_ack,
  input  logic        ext_wr,
  input  logic [63:0] ext_wr_addr
);

  localparam int BEATS  = LINE_W / 64;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = 64 - BLK_LEN;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  fill_state_e        state_d, state_q;
  logic [BLK_LEN-1:0] blk_d, blk_q;
  logic [BEAT_W-1:0]  beat_d, beat_q;
  logic [LINE_W-1:0]  line_d, line_q;
  logic [LINE_W-1:0]  rdata_d, rdata_q;
  logic               stale_d, stale_q;
  logic [63:0]        m_addr_d, m_addr_q;
  logic               m_rd_d, m_rd_q;
  logic               dv_d, dv_q;

  logic               ext_hit;
  logic [OFF_W-1:0]   unused_ext_off;
  logic               inv_o;
  logic [BLK_LEN-1:0] inv_addr_o;

  assign ext_hit        = ext_wr && (ext_wr_addr[63:OFF_W] == blk_q);
  assign unused_ext_off = ext_wr_addr[OFF_W-1:0];

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    beat_d   = beat_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    stale_d  = stale_q;
    m_addr_d = m_addr_q;
    m_rd_d   = m_rd_q;
    dv_d     = 1'b0;
    unique case (state_q)
      // A write landing in the accept cycle precedes every read, so no stale here.
      ST_IDLE: begin
        if (bus.b_rd_d) begin
          blk_d    = bus.b_addr_d;
          beat_d   = '0;
          stale_d  = 1'b0;
          m_addr_d = {bus.b_addr_d, {OFF_W{1'b0}}};
          m_rd_d   = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (ext_hit) stale_d = 1'b1;
        if (m_ack) begin
          // A write seen before or with this ack makes the beat suspect: refetch all.
          if (stale_q || ext_hit) begin
            beat_d   = '0;
            m_addr_d = {blk_q, {OFF_W{1'b0}}};
            stale_d  = 1'b0;
          end else begin
            line_d[64*int'(beat_q) +: 64] = m_rdata;
            if (beat_q == LAST_BEAT) begin
              m_rd_d  = 1'b0;
              dv_d    = 1'b1;
              rdata_d = line_d;
              state_d = ST_RESP;
            end else begin
              beat_d   = beat_q + BEAT_W'(1);
              m_addr_d = m_addr_q + 64'd8;
            end
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      blk_q    <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      rdata_q  <= '0;
      stale_q  <= 1'b0;
      m_addr_q <= '0;
      m_rd_q   <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      rdata_q  <= rdata_d;
      stale_q  <= stale_d;
      m_addr_q <= m_addr_d;
      m_rd_q   <= m_rd_d;
      dv_q     <= dv_d;
    end
  end

  dmem_inv_gen #(.BLK_LEN(BLK_LEN)) u_inv_gen (
    .clk         (clk),
    .rst         (rst),
    .ext_wr      (ext_wr),
    .ext_wr_addr (ext_wr_addr),
    .inv         (inv_o),
    .inv_addr    (inv_addr_o)
  );

  assign bus.b_rdata_d    = rdata_q;
  assign bus.b_dv_d       = dv_q;
  assign bus.inv          = inv_o;
  assign bus.b_inv_addr_d = inv_addr_o;
  assign m_addr           = m_addr_q;
  assign m_rd             = m_rd_q;

endmodule

// File: tb/tb_dmem_fill.sv
// Directed bench for dmem_fill: memory model with per-beat stalls, per-cycle
// compare against a behavioural model, plus literal expectations per scenario.
module tb_dmem_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_addr;
  logic        m_rd;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic        ext_wr;
  logic [63:0] ext_wr_addr;

  dmem_fill_if #(.LINE_W(512), .BLK_LEN(58)) bif ();

  dmem_fill #(.LINE_W(512), .BLK_LEN(58)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .m_addr      (m_addr),
    .m_rd        (m_rd),
    .m_rdata     (m_rdata),
    .m_ack       (m_ack),
    .ext_wr      (ext_wr),
    .ext_wr_addr (ext_wr_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int dv_cnt = 0;

  // Memory model: every word holds its own byte address unless overwritten.
  logic [63:0] mem_ovr [logic [63:0]];
  int          stall_pat [8];
  int          wait_left;
  int          st_idx;
  logic [57:0] req_blk;
  logic [63:0] ack_q [$];

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: memory answers the current request, then the edge, then settle.
  task automatic step();
    if (m_rd && wait_left == 0) begin
      m_ack   = 1'b1;
      m_rdata = mem_rd(m_addr);
    end else begin
      m_ack = 1'b0;
      if (m_rd && wait_left > 0) wait_left--;
    end
    @(posedge clk);
    #1;
    if (m_ack) begin
      wait_left = stall_pat[st_idx % 8];
      st_idx++;
    end
    m_ack  = 1'b0;
    ext_wr = 1'b0;
  endtask

  task automatic do_fill(input logic [57:0] blk, input int wr_step,
                         input logic [63:0] wr_addr, input logic [63:0] wr_data,
                         output int lat);
    req_blk   = blk;
    ack_q.delete();
    wait_left = stall_pat[0];
    st_idx    = 1;
    bif.b_addr_d = blk;
    bif.b_rd_d   = 1'b1;
    lat = -1;
    for (int s = 0; s < 300 && lat < 0; s++) begin
      if (s == wr_step) begin
        ext_wr      = 1'b1;
        ext_wr_addr = wr_addr;
        mem_ovr[{wr_addr[63:3], 3'b000}] = wr_data;
      end
      step();
      if (bif.b_dv_d) lat = s + 1;
    end
    if (lat < 0) chk("fill_timeout", 64'd0, 64'd1);
    step();
    bif.b_rd_d = 1'b0;
  endtask

  // Per-cycle compare against the behavioural model.
  initial begin
    logic        p_ext, p_rd, p_ack;
    logic [63:0] p_ea, p_addr, base;
    forever begin
      @(posedge clk);
      p_ext = ext_wr; p_ea = ext_wr_addr; p_rd = m_rd; p_ack = m_ack; p_addr = m_addr;
      #1;
      if (rst) continue;
      chk("inv_pulse", {63'd0, bif.inv}, {63'd0, p_ext});
      if (p_ext) chk("inv_addr", {6'd0, bif.b_inv_addr_d}, p_ea >> 6);
      if (p_rd && !p_ack && m_rd) chk("m_addr_hold", m_addr, p_addr);
      if (m_rd) chk("m_addr_align", {61'd0, m_addr[2:0]}, 64'd0);
      if (p_rd && p_ack) ack_q.push_back(p_addr);
      if (bif.b_dv_d) begin
        dv_cnt++;
        base = {req_blk, 6'd0};
        for (int i = 0; i < 8; i++)
          chk("line_word", bif.b_rdata_d[64*i +: 64], mem_rd(base + 64'(8*i)));
        if (ack_q.size() < 8) chk("ack_count", 64'(ack_q.size()), 64'd8);
        else for (int i = 0; i < 8; i++)
          chk("ack_order", ack_q[ack_q.size()-8+i], base + 64'(8*i));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int dv0;
    rst = 1'b1; ext_wr = 1'b0; ext_wr_addr = '0; m_ack = 1'b0; m_rdata = '0;
    bif.b_rd_d = 1'b0; bif.b_addr_d = '0;
    wait_left = 0; st_idx = 0; req_blk = '0;
    for (int i = 0; i < 8; i++) stall_pat[i] = 0;
    step(); step();
    chk("rst_dv",       {63'd0, bif.b_dv_d}, 64'd0);
    chk("rst_inv",      {63'd0, bif.inv}, 64'd0);
    chk("rst_m_rd",     {63'd0, m_rd}, 64'd0);
    chk("rst_m_addr",   m_addr, 64'd0);
    chk("rst_rdata",    {63'd0, |bif.b_rdata_d}, 64'd0);
    chk("rst_inv_addr", {6'd0, bif.b_inv_addr_d}, 64'd0);
    rst = 1'b0;
    step();

    // Zero-wait fill of block 0x10.
    do_fill(58'h10, -1, '0, '0, lat);
    chk("zw_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 8; i++) chk("zw_word", bif.b_rdata_d[64*i +: 64], 64'h400 + 64'(8*i));
    for (int i = 0; i < 8 && i < ack_q.size(); i++) chk("zw_m_addr_seq", ack_q[i], 64'h400 + 64'(8*i));
    chk("zw_ack_total", 64'(ack_q.size()), 64'd8);

    // Stalled fill: 9 wait cycles in total.
    stall_pat = '{1, 0, 3, 2, 0, 1, 0, 2};
    do_fill(58'h10, -1, '0, '0, lat);
    chk("stall_latency", 64'(lat), 64'd18);
    for (int i = 0; i < 8; i++) chk("stall_word", bif.b_rdata_d[64*i +: 64], 64'h400 + 64'(8*i));
    for (int i = 0; i < 8; i++) stall_pat[i] = 0;

    // Write to 0x418 with the beat-5 ack: restart, post-write data returned.
    do_fill(58'h10, 6, 64'h418, 64'hCAFE_0000_0000_0003, lat);
    chk("stale_b5_latency", 64'(lat), 64'd15);
    chk("stale_b5_word3", bif.b_rdata_d[64*3 +: 64], 64'hCAFE_0000_0000_0003);
    chk("stale_b5_word2", bif.b_rdata_d[64*2 +: 64], 64'h410);
    mem_ovr.delete();

    // Write with the last beat's ack: restart instead of RESP.
    do_fill(58'h10, 8, 64'h400, 64'h1234, lat);
    chk("stale_last_latency", 64'(lat), 64'd17);
    chk("stale_last_word0", bif.b_rdata_d[63:0], 64'h1234);
    mem_ovr.delete();

    // Write during a wait cycle: the next ack is discarded.
    for (int i = 0; i < 8; i++) stall_pat[i] = 1;
    do_fill(58'h10, 3, 64'h408, 64'hBEEF, lat);
    chk("stale_wait_latency", 64'(lat), 64'd21);
    chk("stale_wait_word1", bif.b_rdata_d[127:64], 64'hBEEF);
    for (int i = 0; i < 8; i++) stall_pat[i] = 0;
    mem_ovr.delete();

    // Back-to-back external writes.
    for (int k = 0; k < 3; k++) begin
      ext_wr = 1'b1;
      ext_wr_addr = 64'h800 + 64'(64*k);
      step();
      chk("b2b_inv", {63'd0, bif.inv}, 64'd1);
      chk("b2b_inv_addr", {6'd0, bif.b_inv_addr_d}, 64'h20 + 64'(k));
    end
    step();
    chk("b2b_inv_end", {63'd0, bif.inv}, 64'd0);

    // Request held through RESP: exactly one line, no second fill.
    dv0 = dv_cnt;
    do_fill(58'h21, -1, '0, '0, lat);
    chk("hold_latency", 64'(lat), 64'd9);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_no_refill", {63'd0, m_rd}, 64'd0);
    end
    chk("hold_dv_count", 64'(dv_cnt - dv0), 64'd1);

    // Asynchronous reset in the middle of a fill.
    dv0 = dv_cnt;
    req_blk = 58'h20; ack_q.delete(); wait_left = 0; st_idx = 1;
    bif.b_addr_d = 58'h20; bif.b_rd_d = 1'b1;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_m_rd",     {63'd0, m_rd}, 64'd0);
    chk("arst_m_addr",   m_addr, 64'd0);
    chk("arst_dv",       {63'd0, bif.b_dv_d}, 64'd0);
    chk("arst_rdata",    {63'd0, |bif.b_rdata_d}, 64'd0);
    chk("arst_inv_addr", {6'd0, bif.b_inv_addr_d}, 64'd0);
    bif.b_rd_d = 1'b0;
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    chk("arst_no_dv", 64'(dv_cnt - dv0), 64'd0);
    do_fill(58'h20, -1, '0, '0, lat);
    chk("arst_refill_latency", 64'(lat), 64'd9);
    chk("arst_refill_word0", bif.b_rdata_d[63:0], 64'h800);
    chk("arst_refill_word7", bif.b_rdata_d[511:448], 64'h838);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
